// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one subtractive GCD engine among N
// requesters and returns each result tagged with the owner's index.
// Ports: clk, rst_n (sync, active-low); req/a_in/b_in/gnt toward the
// clients; busy status; res_valid/res_ready/res_data/res_id/res_err out.
module gcd_rr_scheduler #(
  parameter int W   = 16,
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_data,
  output logic [IDW-1:0] res_id,
  output logic           res_err
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESULT
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic [IDW-1:0] rid_q, rid_d;
  logic           rerr_q, rerr_d;
  // Low for the first cycle after reset so no grant can
  // issue before the block has settled.
  logic           init_q, init_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           grant_ok;
  logic           done;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  assign grant_ok = rst_n && init_q &&
                    (state_q == IDLE) && win_found;

  assign done = (a_q == b_q) || (a_q == '0) ||
                (b_q == '0);

  always_comb begin
    gnt = '0;
    if (grant_ok) gnt[win_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    rdata_d = rdata_q;
    rid_d   = rid_q;
    rerr_d  = rerr_q;
    init_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          a_d     = a_in[win_idx*W +: W];
          b_d     = b_in[win_idx*W +: W];
          id_d    = win_idx;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (done) begin
          rdata_d = (a_q == '0) ? b_q : a_q;
          rerr_d  = (a_q == '0) && (b_q == '0);
          rid_d   = id_q;
          state_d = RESULT;
        end else if (a_q < b_q) begin
          b_d = b_q - a_q;
        end else begin
          a_d = a_q - b_q;
        end
      end
      RESULT: begin
        if (res_ready) begin
          ptr_d   = (id_q == IDW'(N - 1)) ?
                    '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      rid_q   <= '0;
      rerr_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      rerr_q  <= rerr_d;
      init_q  <= init_d;
    end
  end

  // Outputs are forced quiet while reset is held, even
  // before the first reset edge has been sampled.
  assign busy      = rst_n && (state_q != IDLE);
  assign res_valid = rst_n && (state_q == RESULT);
  assign res_data  = rst_n ? rdata_q : '0;
  assign res_id    = rst_n ? rid_q : '0;
  assign res_err   = rst_n && rerr_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler: latency, zero
// operands, round-robin order, backpressure, reset abort.
module tb_gcd_rr_scheduler;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic           res_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bz    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_rr_scheduler #(.W(W), .N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int r,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    a_in = '0;
    b_in = '0;
    a_in[r*W +: W] = a;
    b_in[r*W +: W] = b;
  endtask

  task automatic wait_gnt(output int g, output int t);
    bit hit = 1'b0;
    g = 0;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      if (!hit) begin
        #1;
        if (gnt != '0) begin
          hit = 1'b1;
          g = int'(gnt);
          t = cyc;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (!hit) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int t);
    bit hit = 1'b0;
    t = -1;
    for (int i = 0; i < 70000; i++) begin
      if (!hit) begin
        #1;
        if (!busy) bz++;
        if (res_valid) begin
          hit = 1'b1;
          t = cyc;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (!hit) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_one(input string tag, input int r,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input int ed, input int eerr,
                         input int k);
    int g, tg, tv;
    req = '0;
    req[r] = 1'b1;
    drive(r, a, b);
    res_ready = 1'b1;
    wait_gnt(g, tg);
    chk({tag, "_gnt"}, g, 1 << r);
    @(negedge clk);
    req  = '0;
    a_in = '1;
    b_in = '1;
    bz = 0;
    wait_valid(tv);
    chk({tag, "_lat"}, tv - tg, k + 2);
    chk({tag, "_data"}, int'(res_data), ed);
    chk({tag, "_id"}, int'(res_id), r);
    chk({tag, "_err"}, int'(res_err), eerr);
    chk({tag, "_busy"}, bz, 0);
    @(negedge clk);
    #1;
    chk({tag, "_vdrop"}, int'(res_valid), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int g, tg, tv, th, hb;
    rst_n     = 1'b0;
    req       = '0;
    res_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_data", int'(res_data), 0);
    chk("rst_id", int'(res_id), 0);
    chk("rst_err", int'(res_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("single", 0, 16'd12, 16'd18, 6, 0, 2);
    run_one("zero", 2, 16'd0, 16'd0, 0, 1, 0);
    run_one("bzero", 2, 16'd7, 16'd0, 7, 0, 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    req = '1;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = 16'd9;
      b_in[i*W +: W] = 16'd6;
    end
    th = -1;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, tg);
      chk("rr_gnt", g, 1 << (i % N));
      if (th >= 0) chk("rr_gap", tg - th, 1);
      @(negedge clk);
      wait_valid(tv);
      chk("rr_data", int'(res_data), 3);
      chk("rr_id", int'(res_id), i % N);
      th = tv;
      @(negedge clk);
    end

    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = 16'd35;
      b_in[i*W +: W] = 16'd14;
    end
    wait_gnt(g, tg);
    chk("bp_gnt", g, 2);
    @(negedge clk);
    wait_valid(tv);
    chk("bp_lat", tv - tg, 5);
    chk("bp_data", int'(res_data), 7);
    hb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (!res_valid || res_data != 16'd7 ||
          gnt != '0 || res_id != 2'd1)
        hb++;
    end
    chk("bp_hold", hb, 0);
    res_ready = 1'b1;
    th = cyc;
    @(negedge clk);
    wait_gnt(g, tg);
    chk("bp_next_gnt", g, 4);
    chk("bp_next_gap", tg - th, 1);
    @(negedge clk);
    req = '0;
    wait_valid(tv);
    chk("bp_next_id", int'(res_id), 2);
    @(negedge clk);

    run_one("pre", 1, 16'd35, 16'd14, 7, 0, 3);

    req = 4'b0001;
    drive(0, 16'd1, 16'd1000);
    wait_gnt(g, tg);
    chk("ab_gnt", g, 1);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0110;
    a_in = '0;
    b_in = '0;
    a_in[1*W +: W] = 16'd35;
    b_in[1*W +: W] = 16'd14;
    a_in[2*W +: W] = 16'd8;
    b_in[2*W +: W] = 16'd12;
    @(negedge clk);
    #1;
    chk("ab_rst_gnt", int'(gnt), 0);
    chk("ab_rst_busy", int'(busy), 0);
    chk("ab_rst_valid", int'(res_valid), 0);
    chk("ab_rst_data", int'(res_data), 0);
    chk("ab_rst_id", int'(res_id), 0);
    rst_n = 1'b1;
    #1;
    chk("ab_rel_gnt", int'(gnt), 0);
    @(negedge clk);
    wait_gnt(g, tg);
    chk("ab_ptr_gnt", g, 2);
    @(negedge clk);
    req = '0;
    wait_valid(tv);
    chk("ab_res_data", int'(res_data), 7);
    chk("ab_res_id", int'(res_id), 1);
    chk("ab_res_lat", tv - tg, 5);
    @(negedge clk);

    run_one("equal", 3, 16'd255, 16'd255, 255, 0, 0);
    run_one("maxw", 0, 16'hFFFF, 16'd1, 1, 0, 65534);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
